ezusb_gpio_arbiter: RTL and testbench
=====================================

Name: ezusb_gpio_arbiter

Overview:
- Shares the single 4-bit default-interface GPIO resource between NREQ on-FPGA requesters.
- Owner's output nibble is driven into the GPIO block's wired-OR `out` port; all others contribute 0.
- Round-robin grant, guard interval of forced-zero output on every ownership change, optional hold timeout with revocation.
- Input nibble from the GPIO block is broadcast unchanged to all requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GUARD_CYCLES, 48, clk cycles of forced-zero output before any grant (2 us at 24 MHz); 0 allowed.
- HOLD_MAX, 0, maximum grant length in clk cycles; 0 disables the timeout.

Ports:
- clk  input  1  system clock, min 24 MHz.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NREQ  level request; requester i holds req[i] high while it wants the GPIOs.
- req_out  input  4*NREQ  requester i's output nibble at bits [4i+3:4i].
- gnt  output  NREQ  one-hot grant, registered.
- owner  output  3  index of the current owner; valid only while |gnt.
- timeout  output  1  one-cycle pulse on revocation.
- gpio_out  output  4  to the GPIO block `out`, registered.
- gpio_in  input  4  from the GPIO block `in`.
- in_bcast  output  4  gpio_in registered once, to all requesters.

Behaviour:
- Reset (reset_n low at an edge):
  - gnt=0, owner=0, timeout=0, gpio_out=0, in_bcast=0.
  - State IDLE, round-robin pointer=0, revoke mask=0, counters=0.
  - Reset mid-grant or mid-guard aborts with no timeout pulse.
- States: IDLE, GUARD, OWNED.
- IDLE:
  - eligible = req & ~mask.
  - If eligible≠0, select the first eligible index at or after the pointer (wrap modulo NREQ).
  - Latch the selection into sel, load guard_cnt=GUARD_CYCLES, go to GUARD.
  - gpio_out=0.
- GUARD:
  - If req[sel] is low, go to IDLE; pointer unchanged; no grant.
  - Else if guard_cnt==0, go to OWNED: gnt[sel]=1, owner=sel, hold_cnt=0.
  - Else guard_cnt decrements.
  - gpio_out=0 throughout.
  - Latency: gnt rises GUARD_CYCLES+1 edges after the edge that samples req in IDLE (1 edge when GUARD_CYCLES=0).
- OWNED:
  - Each edge: gpio_out <= req_out[owner] slice, so gpio_out lags req_out by 1 cycle. hold_cnt increments, saturating.
  - Release: req[owner] sampled low. gnt=0 and gpio_out=0 at that same edge; pointer=owner+1 mod NREQ; go to IDLE.
  - Timeout (HOLD_MAX≠0): on the edge where hold_cnt==HOLD_MAX-1 with req[owner] high, revoke instead of updating gpio_out. gnt=0, gpio_out=0, timeout=1 for one cycle, mask[owner]=1, pointer advances, go to IDLE.
  - Release and timeout on the same edge count as a release: no pulse, no mask.
- Mask:
  - mask[i] clears on any edge where req[i] is low.
  - A revoked requester must drop req before it can win again.
- A single requester re-requesting after release is granted again; the pointer wraps to it. The guard interval always applies.
- in_bcast <= gpio_in every cycle, in all states.
- owner width is fixed at 3; upper bits are 0 when NREQ≤4.

Decomposition:
- Package ezusb_gpio_pkg: GPIO_W=4, state encoding localparams (IDLE, GUARD, OWNED), OWNER_W=3.
- One combinational sub-module ezusb_rr_pick (NREQ), mapping eligible vector + pointer to index and valid.
- Everything else stays in the top module.

Test Plan:
- Reset, then req=4'b0001, GUARD_CYCLES=3 → gnt=0001 exactly 4 edges after req is sampled. gpio_out=0 until 1 edge after gnt, then equals req_out[3:0]=4'hA.
- req=4'b1111 held; each owner drops req 10 cycles after grant → grant order 0,1,2,3,0. gpio_out=0 during every 3-cycle guard.
- req[2] pulsed high then low during GUARD → no gnt, state returns to IDLE, pointer unchanged. Next req[2] is granted normally.
- HOLD_MAX=16, req[1] held forever, req[0] high → gnt[1] drops after 16 cycles, timeout pulses 1 cycle, requester 0 is granted next. Requester 1 is not regranted until req[1] toggles low then high.
- Release and timeout on the same edge (req[owner] drops at cycle HOLD_MAX) → no timeout pulse, mask stays 0.
- reset_n low for 1 cycle mid-OWNED with gpio_out=4'hF → next edge gnt=0, gpio_out=0, timeout=0; after release of reset, re-arbitration starts from pointer 0.

Source files
------------

// File: rtl/ezusb_gpio_pkg.sv
// Shared constants and state encoding for the EZ-USB GPIO arbiter.
package ezusb_gpio_pkg;

  localparam int GPIO_W  = 4;
  localparam int OWNER_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_OWNED = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GUARD = ST_GUARD,
    OWNED = ST_OWNED
  } state_e;

endpackage

// File: rtl/ezusb_rr_pick.sv
// Round-robin selector: first eligible index at or after the pointer,
// wrapping modulo NREQ.
module ezusb_rr_pick
  import ezusb_gpio_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    elig_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic [OWNER_W-1:0] idx_o,
  output logic               valid_o
);

  int best_off;
  int off;

  // Pick the eligible index with the smallest distance ahead of the pointer.
  always_comb begin
    idx_o    = '0;
    best_off = NREQ;
    off      = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - int'(ptr_i)) % NREQ;
      if (elig_i[i] && (off < best_off)) begin
        best_off = off;
        idx_o    = OWNER_W'(i);
      end
    end
  end

  assign valid_o = |elig_i;

endmodule

// File: rtl/ezusb_gpio_arbiter.sv
// Shares the 4-bit GPIO resource among NREQ requesters: round-robin grant,
// forced-zero guard before every grant, optional hold timeout with revocation.
// Handshake: a requester holds req[i] high as long as it wants the pins; it
// owns them exactly while gnt[i] is high and drops req[i] to release.
module ezusb_gpio_arbiter
  import ezusb_gpio_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int GUARD_CYCLES = 48,
  parameter int HOLD_MAX     = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [GPIO_W*NREQ-1:0] req_out,
  output logic [NREQ-1:0]        gnt,
  output logic [OWNER_W-1:0]     owner,
  output logic                   timeout,
  output logic [GPIO_W-1:0]      gpio_out,
  input  logic [GPIO_W-1:0]      gpio_in,
  output logic [GPIO_W-1:0]      in_bcast
);

  localparam int GCNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int HCNT_W = $clog2(HOLD_MAX + 2);
  localparam logic [GCNT_W-1:0]  GUARD_LOAD = GCNT_W'(GUARD_CYCLES);
  localparam logic [HCNT_W-1:0]  HOLD_LAST  = (HOLD_MAX > 0) ? HCNT_W'(HOLD_MAX - 1) : '0;
  localparam logic [OWNER_W-1:0] LAST_IDX   = OWNER_W'(NREQ - 1);

  state_e              state_q, state_d;
  logic [OWNER_W-1:0]  sel_q, sel_d;
  logic [OWNER_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]     mask_q, mask_d;
  logic [GCNT_W-1:0]   guard_q, guard_d;
  logic [HCNT_W-1:0]   hold_q, hold_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic                timeout_q, timeout_d;
  logic [GPIO_W-1:0]   gpio_q, gpio_d;
  logic [GPIO_W-1:0]   in_bcast_q;

  logic [NREQ-1:0]     elig;
  logic [OWNER_W-1:0]  pick_idx;
  logic                pick_valid;
  logic [NREQ-1:0]     sel_oh;
  logic                sel_req;
  logic                owner_req;
  logic [GPIO_W-1:0]   owner_nib;
  logic [OWNER_W-1:0]  owner_inc;

  assign elig = req & ~mask_q;

  ezusb_rr_pick #(.NREQ(NREQ)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Decode the latched candidate and the owner's output nibble.
  always_comb begin
    sel_oh    = '0;
    sel_req   = 1'b0;
    owner_nib = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_q == OWNER_W'(i)) begin
        sel_oh[i] = 1'b1;
        sel_req   = req[i];
      end
      if (owner_q == OWNER_W'(i)) begin
        owner_nib = req_out[GPIO_W*i +: GPIO_W];
      end
    end
  end

  // gnt_q is one-hot on the owner while OWNED, so this is req[owner].
  assign owner_req = |(req & gnt_q);
  assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Next-state and registered-output logic for IDLE / GUARD / OWNED.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    mask_d    = mask_q & req;
    guard_d   = guard_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    gpio_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          guard_d = GUARD_LOAD;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (!sel_req) begin
          state_d = IDLE;
        end else if (guard_q == '0) begin
          state_d = OWNED;
          gnt_d   = sel_oh;
          owner_d = sel_q;
          hold_d  = '0;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          // Release wins over a coincident timeout: no pulse, no mask.
          gnt_d   = '0;
          ptr_d   = owner_inc;
          state_d = IDLE;
        end else if ((HOLD_MAX != 0) && (hold_q == HOLD_LAST)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          mask_d    = (mask_q & req) | gnt_q;
          ptr_d     = owner_inc;
          state_d   = IDLE;
        end else begin
          gpio_d = owner_nib;
          if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      mask_q     <= '0;
      guard_q    <= '0;
      hold_q     <= '0;
      gnt_q      <= '0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
      gpio_q     <= '0;
      in_bcast_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      guard_q    <= guard_d;
      hold_q     <= hold_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      timeout_q  <= timeout_d;
      gpio_q     <= gpio_d;
      in_bcast_q <= gpio_in;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign timeout  = timeout_q;
  assign gpio_out = gpio_q;
  assign in_bcast = in_bcast_q;

endmodule

// File: tb/tb_ezusb_gpio_arbiter.sv
// Bench for ezusb_gpio_arbiter: timestamp-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ezusb_gpio_arbiter;
  import ezusb_gpio_pkg::*;

  localparam int N = 4;
  localparam int G = 3;
  localparam int H = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_out;
  logic [N-1:0]   gnt;
  logic [2:0]     owner;
  logic           timeout;
  logic [3:0]     gpio_out;
  logic [3:0]     gpio_in;
  logic [3:0]     in_bcast;

  initial forever #5 clk = ~clk;

  ezusb_gpio_arbiter #(.NREQ(N), .GUARD_CYCLES(G), .HOLD_MAX(H)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_out  (req_out),
    .gnt      (gnt),
    .owner    (owner),
    .timeout  (timeout),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .in_bcast (in_bcast)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Timestamps instead of counters: a candidate chosen at edge t is granted at
  // edge t+G+1 if it keeps requesting; an owner granted at edge g is revoked at
  // edge g+H if it is still requesting.
  int          cyc = 0;
  bit          chk_en = 0;
  int          m_owner, m_cand, m_grant_due, m_grant_cyc, m_ptr;
  logic [N-1:0] m_blk, m_nb;
  logic        e_to;
  logic [3:0]  e_gpio, e_in;

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_owner = -1; m_cand = -1; m_ptr = 0; m_blk = '0;
      e_to = 1'b0; e_gpio = 4'h0; e_in = 4'h0;
      chk_en = 1;
    end else begin
      e_in   = gpio_in;
      e_to   = 1'b0;
      e_gpio = 4'h0;
      m_nb   = m_blk & req;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else if (cyc - m_grant_cyc == H) begin
          e_to = 1'b1; m_nb[m_owner] = 1'b1;
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else begin
          e_gpio = req_out[4*m_owner +: 4];
        end
      end else if (m_cand >= 0) begin
        if (!req[m_cand]) m_cand = -1;
        else if (cyc == m_grant_due) begin
          m_owner = m_cand; m_grant_cyc = cyc; m_cand = -1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (m_cand < 0 && req[(m_ptr + k) % N] && !m_blk[(m_ptr + k) % N]) begin
            m_cand = (m_ptr + k) % N;
            m_grant_due = cyc + G + 1;
          end
        end
      end
      m_blk = m_nb;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("m_timeout", timeout, e_to);
      check("m_gpio_out", gpio_out, e_gpio);
      check("m_in_bcast", in_bcast, e_in);
      if (m_owner >= 0) check("m_owner", owner, m_owner);
    end
  end

  // ---------------- drivers ----------------
  logic [3:0] gin_tab [5] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3};
  initial begin
    gpio_in = 4'h0;
    forever begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        gpio_in = gin_tab[j];
      end
    end
  end

  function automatic int oh2idx(input logic [N-1:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Wait up to max negedges for any grant; n = negedges waited, -1 on expiry.
  task automatic wait_gnt(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  bit t2_on = 0;
  int bad_guard = 0;
  always @(negedge clk) if (t2_on && gnt == '0 && gpio_out != 4'h0) bad_guard++;

  // ---------------- directed scenarios ----------------
  int n, o, hold, busy;
  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n = 1'b0;
    req     = '0;
    req_out = 16'h9C5A;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_owner", owner, 0);
    check("rst_timeout", timeout, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_in_bcast", in_bcast, 0);
    reset_n = 1'b1;

    // Single requester, guard of 3: grant 4 edges after the sampling edge.
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(20, n);
    check("t1_latency", n - 1, 4);
    check("t1_gnt", gnt, 4'b0001);
    check("t1_gpio_at_grant", gpio_out, 4'h0);
    @(negedge clk);
    check("t1_gpio_owned", gpio_out, 4'hA);
    req_out[3:0] = 4'h3;
    check("t1_gpio_lag_old", gpio_out, 4'hA);
    @(negedge clk);
    check("t1_gpio_lag_new", gpio_out, 4'h3);
    req = 4'b0000;
    @(negedge clk);
    check("t1_release_gnt", gnt, 0);
    check("t1_release_gpio", gpio_out, 0);
    repeat (3) @(negedge clk);

    // All four requesting: rotation 0,1,2,3,0 from a fresh pointer.
    do_reset(2);
    req_out = 16'h9C5A;
    req     = 4'b1111;
    t2_on   = 1;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(40, n);
      o = oh2idx(gnt);
      order[g] = o;
      repeat (9) @(negedge clk);
      if (o >= 0) req[o] = 1'b0;
      @(negedge clk);
      if (o >= 0 && g < 4) req[o] = 1'b1;
    end
    req   = 4'b0000;
    t2_on = 0;
    for (int g = 0; g < 5; g++) check("t2_order", order[g], exp_order[g]);
    check("t2_guard_zero", bad_guard, 0);
    repeat (3) @(negedge clk);

    // Request withdrawn during guard: abort, pointer unchanged (1).
    req = 4'b0100;
    @(negedge clk);
    check("t3_state_guard", dut.state_q, GUARD);
    req = 4'b0000;
    @(negedge clk);
    check("t3_state_idle", dut.state_q, IDLE);
    check("t3_ptr", dut.ptr_q, 1);
    repeat (5) @(negedge clk);
    check("t3_no_gnt", gnt, 0);
    req = 4'b0100;
    wait_gnt(20, n);
    check("t3_latency", n - 1, 4);
    check("t3_gnt", gnt, 4'b0100);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Timeout: owner 1 held past 16 cycles is revoked, 0 goes next.
    req = 4'b0010;
    wait_gnt(20, n);
    check("t4_gnt1", gnt, 4'b0010);
    req  = 4'b0011;
    hold = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt[1]) hold++;
      else break;
    end
    check("t4_hold_len", hold, 16);
    check("t4_timeout_pulse", timeout, 1);
    @(negedge clk);
    check("t4_timeout_one_cycle", timeout, 0);
    wait_gnt(20, n);
    check("t4_next_gnt0", gnt, 4'b0001);
    repeat (3) @(negedge clk);
    req  = 4'b0010;
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) busy++;
    end
    check("t4_masked_no_regrant", busy, 0);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0010;
    wait_gnt(20, n);
    check("t4_regrant_latency", n - 1, 4);
    check("t4_regrant_gnt", gnt, 4'b0010);

    // Release on the same edge the timeout would fire: release wins.
    repeat (15) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("t5_gnt", gnt, 0);
    check("t5_no_timeout", timeout, 0);
    check("t5_mask", dut.mask_q, 0);
    repeat (3) @(negedge clk);

    // Reset mid-grant with gpio_out=F; arbitration restarts from pointer 0.
    req_out = 16'h9CFA;
    req     = 4'b0010;
    wait_gnt(20, n);
    repeat (2) @(negedge clk);
    check("t6_gpio_F", gpio_out, 4'hF);
    req     = 4'b1111;
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_gpio", gpio_out, 0);
    check("t6_rst_timeout", timeout, 0);
    check("t6_rst_owner", owner, 0);
    reset_n = 1'b1;
    wait_gnt(20, n);
    check("t6_latency", n - 1, 4);
    check("t6_first_gnt", gnt, 4'b0001);
    req = 4'b0000;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
